// File: rtl/uart_rx_ctrl.sv
// Receive sequencer for the UART baud generator: majority-votes each bit, steps
// start/data/parity/stop, and hands finished frames to a valid/ready holding register.
module uart_rx_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              i_rx_en,
    input  logic              i_rxd,
    input  logic              i_voting_edge,
    input  logic              i_sample_edge,
    input  logic [1:0]        i_wls,
    input  logic              i_pen,
    input  logic              i_eps,
    input  logic              i_sp,
    output logic              o_sample_clk_clr,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_rx_perr,
    output logic              o_rx_ferr,
    output logic              o_rx_brk,
    output logic              o_overrun,
    output logic              o_rx_busy
);
    localparam int unsigned CW = ($clog2(DATA_W) < 3) ? 3 : $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_d;
    logic [1:0]             r_ones;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_W-1:0]      r_shreg;
    logic                   r_par;
    logic                   r_f_perr;
    logic                   r_f_ferr;
    logic                   r_f_brk;
    logic                   r_commit;
    logic                   r_brk_lock;
    logic                   r_sample_clk_clr;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_perr;
    logic                   r_rx_ferr;
    logic                   r_rx_brk;
    logic                   r_overrun;

    logic                   w_rxd;
    logic                   w_fall;
    logic                   w_bit;
    logic                   w_par_exp;
    logic                   w_brk;
    logic [CW-1:0]          w_last;

    assign w_rxd     = r_sync[SYNC_STAGES-1];
    assign w_fall    = r_rxd_d & ~w_rxd;
    assign w_bit     = r_ones[1];
    assign w_last    = CW'(i_wls) + CW'(4);
    assign w_par_exp = i_sp ? ~i_eps : (^r_shreg ^ ~i_eps);
    assign w_brk     = (r_shreg == '0) & (i_pen ? (r_par == 1'b0) : 1'b1) & ~w_bit;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_sync  <= '1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            r_rxd_d <= w_rxd;
        end
    end

    // Ones counter: bit value is the majority of the three votes.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ones <= '0;
        end else if (r_state == IDLE || i_sample_edge) begin
            r_ones <= '0;
        end else if (i_voting_edge && w_rxd && r_ones != 2'd3) begin
            r_ones <= r_ones + 2'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state          <= IDLE;
            r_sample_clk_clr <= 1'b1;
            r_bit_cnt        <= '0;
            r_shreg          <= '0;
            r_par            <= 1'b0;
            r_f_perr         <= 1'b0;
            r_f_ferr         <= 1'b0;
            r_f_brk          <= 1'b0;
            r_commit         <= 1'b0;
            r_brk_lock       <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (w_rxd) r_brk_lock <= 1'b0;
            if (!i_rx_en) begin
                r_state          <= IDLE;
                r_sample_clk_clr <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_fall && !r_brk_lock) begin
                            r_state          <= START;
                            r_sample_clk_clr <= 1'b0;
                        end
                    end
                    START: begin
                        if (i_sample_edge) begin
                            if (w_bit) begin
                                r_state          <= IDLE;
                                r_sample_clk_clr <= 1'b1;
                            end else begin
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                                r_shreg   <= '0;
                                r_par     <= 1'b0;
                                r_f_perr  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (i_sample_edge) begin
                            r_shreg[r_bit_cnt] <= w_bit;
                            // >= keeps the FSM terminating if wls shrinks mid-frame.
                            if (r_bit_cnt >= w_last) begin
                                r_state <= i_pen ? PARITY : STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CW'(1);
                            end
                        end
                    end
                    PARITY: begin
                        if (i_sample_edge) begin
                            r_par    <= w_bit;
                            r_f_perr <= (w_bit != w_par_exp);
                            r_state  <= STOP;
                        end
                    end
                    STOP: begin
                        if (i_sample_edge) begin
                            r_f_ferr         <= ~w_bit;
                            r_f_brk          <= w_brk;
                            r_commit         <= 1'b1;
                            r_state          <= IDLE;
                            r_sample_clk_clr <= 1'b1;
                            if (w_brk) r_brk_lock <= 1'b1;
                        end
                    end
                    default: begin
                        r_state          <= IDLE;
                        r_sample_clk_clr <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_brk   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_commit) begin
                if (!r_rx_valid || i_rx_ready) begin
                    r_rx_data  <= r_shreg;
                    r_rx_perr  <= r_f_perr;
                    r_rx_ferr  <= r_f_ferr;
                    r_rx_brk   <= r_f_brk;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign o_sample_clk_clr = r_sample_clk_clr;
    assign o_rx_data        = r_rx_data;
    assign o_rx_valid       = r_rx_valid;
    assign o_rx_perr        = r_rx_perr;
    assign o_rx_ferr        = r_rx_ferr;
    assign o_rx_brk         = r_rx_brk;
    assign o_overrun        = r_overrun;
    assign o_rx_busy        = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a divisor-16 baud generator model
// (votes at counts 6/7/8, sample at 9).
module tb_uart_rx_ctrl;
    logic       pclk = 1'b0;
    logic       presetn, rx_en, rxd, pen, eps, sp, rx_ready;
    logic [1:0] wls;
    logic       voting_edge, sample_edge;
    logic       sample_clk_clr, rx_valid, rx_perr, rx_ferr, rx_brk, overrun, rx_busy;
    logic [7:0] rx_data;
    logic [3:0] gen_cnt;

    int checks = 0;
    int errors = 0;
    int frames_n = 0;
    int valid_cyc = 0;
    int ovr_n = 0;
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] cap_data = '0;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    logic       cap_brk = 1'b0;

    always #5 pclk = ~pclk;

    uart_rx_ctrl #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .pclk            (pclk),
        .presetn         (presetn),
        .i_rx_en         (rx_en),
        .i_rxd           (rxd),
        .i_voting_edge   (voting_edge),
        .i_sample_edge   (sample_edge),
        .i_wls           (wls),
        .i_pen           (pen),
        .i_eps           (eps),
        .i_sp            (sp),
        .o_sample_clk_clr(sample_clk_clr),
        .o_rx_data       (rx_data),
        .o_rx_valid      (rx_valid),
        .i_rx_ready      (rx_ready),
        .o_rx_perr       (rx_perr),
        .o_rx_ferr       (rx_ferr),
        .o_rx_brk        (rx_brk),
        .o_overrun       (overrun),
        .o_rx_busy       (rx_busy)
    );

    // Baud generator model: counter held at 0 while cleared.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn)            gen_cnt <= 4'd0;
        else if (sample_clk_clr) gen_cnt <= 4'd0;
        else                     gen_cnt <= gen_cnt + 4'd1;
    end
    assign voting_edge = !sample_clk_clr && (gen_cnt >= 4'd6) && (gen_cnt <= 4'd8);
    assign sample_edge = !sample_clk_clr && (gen_cnt == 4'd9);

    // Frame monitor: a new holding-register load is seen when valid is set
    // after being empty or after a handshake.
    always @(negedge pclk) begin
        #2;
        if (rx_valid && (!prev_valid || prev_hs)) begin
            frames_n++;
            cap_data = rx_data;
            cap_perr = rx_perr;
            cap_ferr = rx_ferr;
            cap_brk  = rx_brk;
        end
        if (rx_valid) valid_cyc++;
        if (overrun)  ovr_n++;
        prev_hs    = rx_valid && rx_ready;
        prev_valid = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned n,
                              input logic use_par, input logic par, input logic stop);
        send_bit(1'b0);
        for (int unsigned i = 0; i < n; i++) send_bit(d[i[2:0]]);
        if (use_par) send_bit(par);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int unsigned k = 0;
        while (rx_busy !== lvl && k < 400) begin
            @(negedge pclk);
            k++;
        end
        chk(tag, 32'(rx_busy), 32'(lvl));
    endtask

    initial begin
        int f0, o0, v0;
        presetn = 1'b0; rx_en = 1'b0; rxd = 1'b1; rx_ready = 1'b1;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_clr",     32'(sample_clk_clr), 32'd1);
        chk("rst_valid",   32'(rx_valid),       32'd0);
        chk("rst_data",    32'(rx_data),        32'h00);
        chk("rst_flags",   32'({rx_perr, rx_ferr, rx_brk}), 32'd0);
        chk("rst_overrun", 32'(overrun),        32'd0);
        chk("rst_busy",    32'(rx_busy),        32'd0);
        presetn = 1'b1; rx_en = 1'b1;
        repeat (4) @(negedge pclk);

        // 8N1 0xA5 with latency check around the commit cycle
        f0 = frames_n; v0 = valid_cyc;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
            begin
                wait_busy(1'b1, "a5_busy_rise");
                wait_busy(1'b0, "a5_busy_fall");
                chk("a5_lat0", 32'(rx_valid), 32'd0);
                @(negedge pclk);
                chk("a5_lat1", 32'(rx_valid), 32'd1);
                chk("a5_data", 32'(rx_data), 32'hA5);
                @(negedge pclk);
                chk("a5_lat2", 32'(rx_valid), 32'd0);
            end
        join
        repeat (8) @(negedge pclk);
        chk("a5_frames", 32'(frames_n - f0), 32'd1);
        chk("a5_vcyc",   32'(valid_cyc - v0), 32'd1);
        chk("a5_flags",  32'({cap_perr, cap_ferr, cap_brk}), 32'd0);
        chk("a5_clr",    32'(sample_clk_clr), 32'd1);

        // 7E1 0x3C: correct even parity bit is 0, send 1
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1);
        repeat (8) @(negedge pclk);
        chk("e1_data", 32'(cap_data), 32'h3C);
        chk("e1_perr", 32'(cap_perr), 32'd1);
        chk("e1_ferr", 32'(cap_ferr), 32'd0);

        // Stick parity, eps=0: parity bit must be 1
        sp = 1'b1; eps = 1'b0;
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
        repeat (8) @(negedge pclk);
        chk("st1_data", 32'(cap_data), 32'h55);
        chk("st1_perr", 32'(cap_perr), 32'd0);
        send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge pclk);
        chk("st0_perr", 32'(cap_perr), 32'd1);

        // Glitch: 2 pclk low is a false start
        wls = 2'b11; pen = 1'b0; sp = 1'b0;
        f0 = frames_n; o0 = ovr_n;
        rxd = 1'b0;
        repeat (2) @(negedge pclk);
        rxd = 1'b1;
        repeat (3) @(negedge pclk);
        chk("gl_start", 32'(rx_busy), 32'd1);
        repeat (40) @(negedge pclk);
        chk("gl_idle",   32'(rx_busy), 32'd0);
        chk("gl_clr",    32'(sample_clk_clr), 32'd1);
        chk("gl_frames", 32'(frames_n - f0), 32'd0);
        chk("gl_ovr",    32'(ovr_n - o0), 32'd0);

        // 5N1 0x1F with stop bit 0
        wls = 2'b00;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge pclk);
        chk("fe_data", 32'(cap_data), 32'h1F);
        chk("fe_ferr", 32'(cap_ferr), 32'd1);
        chk("fe_brk",  32'(cap_brk),  32'd0);

        // Break: line low for 12 bit times
        f0 = frames_n;
        rxd = 1'b0;
        repeat (12 * 16) @(negedge pclk);
        chk("brk_frames", 32'(frames_n - f0), 32'd1);
        chk("brk_data",   32'(cap_data), 32'h00);
        chk("brk_flags",  32'({cap_ferr, cap_brk}), 32'b11);
        chk("brk_hold",   32'(rx_busy), 32'd0);
        rxd = 1'b1;
        repeat (32) @(negedge pclk);

        // Overrun: 0x11 held, 0x22 lost
        wls = 2'b11; rx_ready = 1'b0;
        f0 = frames_n; o0 = ovr_n;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge pclk);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge pclk);
        chk("ov_pulse",  32'(ovr_n - o0), 32'd1);
        chk("ov_data",   32'(rx_data), 32'h11);
        chk("ov_valid",  32'(rx_valid), 32'd1);
        chk("ov_frames", 32'(frames_n - f0), 32'd1);

        // rx_ready asserted exactly on the commit cycle
        f0 = frames_n; o0 = ovr_n;
        fork
            send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
            begin
                wait_busy(1'b1, "cr_busy_rise");
                wait_busy(1'b0, "cr_busy_fall");
                rx_ready = 1'b1;
                @(negedge pclk);
                rx_ready = 1'b0;
            end
        join
        repeat (8) @(negedge pclk);
        chk("cr_data",   32'(rx_data), 32'h22);
        chk("cr_valid",  32'(rx_valid), 32'd1);
        chk("cr_ovr",    32'(ovr_n - o0), 32'd0);
        chk("cr_frames", 32'(frames_n - f0), 32'd1);

        // rx_en dropped mid-DATA
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        chk("en_busy_pre", 32'(rx_busy), 32'd1);
        rx_en = 1'b0;
        @(negedge pclk);
        chk("en_idle",  32'(rx_busy), 32'd0);
        chk("en_clr",   32'(sample_clk_clr), 32'd1);
        chk("en_valid", 32'(rx_valid), 32'd1);
        chk("en_data",  32'(rx_data), 32'h22);
        rxd = 1'b1;
        repeat (20) @(negedge pclk);
        rx_en = 1'b1; rx_ready = 1'b1;
        repeat (4) @(negedge pclk);
        chk("en_drain", 32'(rx_valid), 32'd0);
        f0 = frames_n;
        send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge pclk);
        chk("en_frames", 32'(frames_n - f0), 32'd1);
        chk("en_next",   32'(cap_data), 32'h80);
        chk("en_flags",  32'({cap_perr, cap_ferr, cap_brk}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
